// File: rtl/kore_exec_pkg.sv
// kore_exec_pkg: opcode encodings, execute FSM state type and opcode legality check
// shared by the execute sequencer and its ALU.
// Optional feature macro: KORE_EXEC_MUL_EN (enables opcode 2, MUL).
package kore_exec_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_PASS = 4'd8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   // Codes above OP_PASS are never legal; MUL is legal only when the
   // multiplier is built.
   function automatic logic op_legal(input logic [3:0] code);
      logic ok;
      ok = (code <= OP_PASS);
`ifdef KORE_EXEC_MUL_EN
      ok = ok;
`else
      if (code == OP_MUL) ok = 1'b0;
`endif
      return ok;
   endfunction

endpackage

// File: rtl/kore_exec_alu.sv
// kore_exec_alu: purely combinational ALU for the execute sequencer.
// Ports: a, b (DW operands), op_code (4) in; result (DW), illegal out.
// Optional feature macro: KORE_EXEC_MUL_EN (DW x DW multiplier for opcode 2).
module kore_exec_alu
   import kore_exec_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [3:0]    op_code,
   output logic [DW-1:0] result,
   output logic          illegal
);

   localparam int SW = $clog2(DW);

   // Only the low log2(DW) bits of B form the shift amount.
   logic [SW-1:0] shamt;
   assign shamt = b[SW-1:0];

   always_comb begin
      result  = '0;
      illegal = !op_legal(op_code);
      case (op_code)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
`ifdef KORE_EXEC_MUL_EN
         OP_MUL:  result = a * b;
`else
         OP_MUL:  result = '0;
`endif
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_PASS: result = a;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/kore_exec_fsm.sv
// kore_exec_fsm: execute sequencer - accepts one reg-reg op, reads rs0/rs1 over a single
// RF read port, runs the ALU, writes rd back and pulses eop (err on illegal op_code).
// Ports: clk, rst_n; op_valid/op_ready/op_code/op_rs0/op_rs1/op_rd; rf_rd/rf_raddr/rf_rdata;
// rf_wt/rf_waddr/rf_wdata; busy, eop, err. Accept->write-back latency 4 cycles, 1 op per 5.
// Optional feature macro: KORE_EXEC_MUL_EN (see kore_exec_alu).
module kore_exec_fsm
   import kore_exec_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [3:0]    op_code,
   input  logic [AW-1:0] op_rs0,
   input  logic [AW-1:0] op_rs1,
   input  logic [AW-1:0] op_rd,
   output logic          rf_rd,
   output logic [AW-1:0] rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          rf_wt,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          busy,
   output logic          eop,
   output logic          err
);

   state_t        state, state_nxt;

   logic [3:0]    code_q;
   logic [AW-1:0] rs0_q, rs1_q, rd_q;
   logic [DW-1:0] opa_q;
   logic [DW-1:0] res_q;
   logic          ill_q;

   logic [DW-1:0] alu_res;
   logic          alu_ill;
   logic          accept;

   assign accept = op_valid && (state == IDLE);

   // Operand B is taken straight from the RF read data in EXEC (rs1 read
   // issued in RD1), so it needs no register of its own.
   kore_exec_alu #(.DW(DW)) u_alu (
      .a       (opa_q),
      .b       (rf_rdata),
      .op_code (code_q),
      .result  (alu_res),
      .illegal (alu_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         code_q <= '0;
         rs0_q  <= '0;
         rs1_q  <= '0;
         rd_q   <= '0;
         opa_q  <= '0;
         res_q  <= '0;
         ill_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            code_q <= op_code;
            rs0_q  <= op_rs0;
            rs1_q  <= op_rs1;
            rd_q   <= op_rd;
         end
         if (state == RD1) opa_q <= rf_rdata;
         if (state == EXEC) begin
            res_q <= alu_res;
            ill_q <= alu_ill;
         end
      end
   end

   // Every output is decoded from state plus registered fields, so an
   // asynchronous reset drops strobes immediately.
   always_comb begin
      state_nxt = state;
      op_ready  = 1'b0;
      busy      = 1'b1;
      rf_rd     = 1'b0;
      rf_raddr  = '0;
      rf_wt     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      eop       = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            op_ready = 1'b1;
            busy     = 1'b0;
            if (op_valid) state_nxt = RD0;
         end
         RD0: begin
            rf_rd     = 1'b1;
            rf_raddr  = rs0_q;
            state_nxt = RD1;
         end
         RD1: begin
            rf_rd     = 1'b1;
            rf_raddr  = rs1_q;
            state_nxt = EXEC;
         end
         EXEC: begin
            state_nxt = WB;
         end
         WB: begin
            eop       = 1'b1;
            err       = ill_q;
            rf_wt     = !ill_q;
            rf_waddr  = ill_q ? '0 : rd_q;
            rf_wdata  = ill_q ? '0 : res_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_kore_exec_fsm.sv
module tb_kore_exec_fsm;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst_n;
   logic          op_valid;
   logic          op_ready;
   logic [3:0]    op_code;
   logic [AW-1:0] op_rs0, op_rs1, op_rd;
   logic          rf_rd;
   logic [AW-1:0] rf_raddr;
   logic [DW-1:0] rf_rdata;
   logic          rf_wt;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          busy, eop, err;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rf_mem [32];

   kore_exec_fsm #(.DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_rs0   (op_rs0),
      .op_rs1   (op_rs1),
      .op_rd    (op_rd),
      .rf_rd    (rf_rd),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata),
      .rf_wt    (rf_wt),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .busy     (busy),
      .eop      (eop),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file read port: data valid the cycle after rf_rd.
   always @(posedge clk) begin
      if (rf_rd) rf_rdata <= rf_mem[rf_raddr];
   end

   task automatic test_reset();
      rst_n = 1'b0;
      op_valid = 1'b0;
      op_code = '0; op_rs0 = '0; op_rs1 = '0; op_rd = '0;
      rf_rdata = '0;
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({op_ready, busy, rf_rd, rf_wt, eop, err} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 100000", {op_ready, busy, rf_rd, rf_wt, eop, err});
      end
      checks++;
      if ({rf_raddr, rf_waddr, rf_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_buses raddr %0d waddr %0d wdata %h want 0", rf_raddr, rf_waddr, rf_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Issue one op at the next negedge (T0) and check T1..T5.
   task automatic run_op(input string nm, input logic [3:0] code, input logic [AW-1:0] s0,
                         input logic [AW-1:0] s1, input logic [AW-1:0] d,
                         input logic exp_wt, input logic [DW-1:0] exp_data, input logic exp_err);
      @(negedge clk);
      op_valid = 1'b1; op_code = code; op_rs0 = s0; op_rs1 = s1; op_rd = d;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++; $display("FAIL %s_t0_ready got %b want 1", nm, op_ready);
      end
      @(negedge clk); // T1
      op_valid = 1'b0;
      checks++;
      if ({busy, rf_rd, rf_raddr} !== {1'b1, 1'b1, s0}) begin
         errors++; $display("FAIL %s_t1 busy/rd/raddr got %b/%b/%0d want 1/1/%0d", nm, busy, rf_rd, rf_raddr, s0);
      end
      @(negedge clk); // T2
      checks++;
      if ({rf_rd, rf_raddr} !== {1'b1, s1}) begin
         errors++; $display("FAIL %s_t2 rd/raddr got %b/%0d want 1/%0d", nm, rf_rd, rf_raddr, s1);
      end
      @(negedge clk); // T3
      checks++;
      if ({rf_rd, rf_wt, eop} !== 3'b000) begin
         errors++; $display("FAIL %s_t3 rd/wt/eop got %b want 000", nm, {rf_rd, rf_wt, eop});
      end
      @(negedge clk); // T4
      checks++;
      if ({rf_wt, eop, err} !== {exp_wt, 1'b1, exp_err}) begin
         errors++; $display("FAIL %s_t4 wt/eop/err got %b want %b", nm, {rf_wt, eop, err}, {exp_wt, 1'b1, exp_err});
      end
      if (exp_wt) begin
         checks++;
         if ({rf_waddr, rf_wdata} !== {d, exp_data}) begin
            errors++; $display("FAIL %s_wb waddr %0d wdata %h want %0d %h", nm, rf_waddr, rf_wdata, d, exp_data);
         end
      end
      if (rf_wt === 1'b1) rf_mem[rf_waddr] = rf_wdata;
      @(negedge clk); // T5
      checks++;
      if ({op_ready, busy, eop} !== 3'b100) begin
         errors++; $display("FAIL %s_t5 ready/busy/eop got %b want 100", nm, {op_ready, busy, eop});
      end
   endtask

   task automatic test_add();
      rf_mem[1] = 32'd5; rf_mem[2] = 32'd7;
      run_op("add", 4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 32'd12, 1'b0);
      checks++;
      if (rf_mem[3] !== 32'd12) begin
         errors++; $display("FAIL add_rf r3 got %0d want 12", rf_mem[3]);
      end
   endtask

   task automatic test_sub_sll();
      rf_mem[1] = 32'd3; rf_mem[2] = 32'd5;
      run_op("sub", 4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 32'hFFFF_FFFE, 1'b0);
      rf_mem[1] = 32'd1; rf_mem[2] = 32'h21;
      run_op("sll", 4'd6, 5'd1, 5'd2, 5'd4, 1'b1, 32'h0000_0002, 1'b0);
   endtask

   task automatic test_logic();
      rf_mem[7] = 32'hF0F0_00FF; rf_mem[8] = 32'h0FF0_FF0F; rf_mem[9] = 32'd4;
      run_op("and",  4'd3, 5'd7, 5'd8, 5'd10, 1'b1, 32'h00F0_000F, 1'b0);
      run_op("or",   4'd4, 5'd7, 5'd8, 5'd11, 1'b1, 32'hFFF0_FFFF, 1'b0);
      run_op("xor",  4'd5, 5'd7, 5'd8, 5'd12, 1'b1, 32'hFF00_FFF0, 1'b0);
      run_op("srl",  4'd7, 5'd7, 5'd9, 5'd13, 1'b1, 32'h0F0F_000F, 1'b0);
      run_op("pass", 4'd8, 5'd7, 5'd9, 5'd14, 1'b1, 32'hF0F0_00FF, 1'b0);
      // Same source twice, destination overwrites a source.
      run_op("xor_self", 4'd5, 5'd8, 5'd8, 5'd8, 1'b1, 32'h0, 1'b0);
      run_op("add_rd_rs", 4'd0, 5'd7, 5'd9, 5'd7, 1'b1, 32'hF0F0_0103, 1'b0);
   endtask

   task automatic test_mul();
      rf_mem[1] = 32'h0001_0000; rf_mem[2] = 32'h0001_0000;
`ifdef KORE_EXEC_MUL_EN
      run_op("mul", 4'd2, 5'd1, 5'd2, 5'd5, 1'b1, 32'h0, 1'b0);
`else
      run_op("mul", 4'd2, 5'd1, 5'd2, 5'd5, 1'b0, 32'h0, 1'b1);
`endif
   endtask

   task automatic test_illegal();
      run_op("ill_f", 4'hF, 5'd1, 5'd2, 5'd6, 1'b0, 32'h0, 1'b1);
      run_op("ill_9", 4'h9, 5'd1, 5'd2, 5'd6, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [3:0]    c  [3];
      logic [AW-1:0] d  [3];
      logic [DW-1:0] ex [3];
      rf_mem[20] = 32'd100; rf_mem[21] = 32'd23;
      c[0] = 4'd0; d[0] = 5'd22; ex[0] = 32'd123;
      c[1] = 4'd1; d[1] = 5'd23; ex[1] = 32'd77;
      c[2] = 4'd4; d[2] = 5'd24; ex[2] = 32'd119;
      @(negedge clk);
      op_valid = 1'b1; op_code = c[0]; op_rs0 = 5'd20; op_rs1 = 5'd21; op_rd = d[0];
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (op_ready !== 1'b1) begin
            errors++; $display("FAIL b2b%0d_t0_ready got %b want 1", k, op_ready);
         end
         for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            // Disturb every field while busy.
            op_code = 4'd5; op_rs0 = 5'd1; op_rs1 = 5'd2; op_rd = 5'd31;
            checks++;
            if (op_ready !== 1'b0) begin
               errors++; $display("FAIL b2b%0d_t%0d_ready got %b want 0", k, t, op_ready);
            end
         end
         @(negedge clk); // T4
         checks++;
         if ({op_ready, rf_wt, rf_waddr, rf_wdata} !== {1'b0, 1'b1, d[k], ex[k]}) begin
            errors++; $display("FAIL b2b%0d_wb ready/wt %b%b waddr %0d wdata %0d want 01 %0d %0d",
                               k, op_ready, rf_wt, rf_waddr, rf_wdata, d[k], ex[k]);
         end
         if (rf_wt === 1'b1) rf_mem[rf_waddr] = rf_wdata;
         if (k < 2) begin
            op_code = c[k+1]; op_rs0 = 5'd20; op_rs1 = 5'd21; op_rd = d[k+1];
         end else begin
            op_valid = 1'b0;
         end
         @(negedge clk); // T5 = next T0
      end
      checks++;
      if ({op_ready, busy} !== 2'b10) begin
         errors++; $display("FAIL b2b_end ready/busy got %b want 10", {op_ready, busy});
      end
   endtask

   task automatic test_reset_mid_op();
      logic saw_wt;
      rf_mem[1] = 32'd5; rf_mem[2] = 32'd7; rf_mem[15] = 32'hDEAD_BEEF;
      @(negedge clk);
      op_valid = 1'b1; op_code = 4'd0; op_rs0 = 5'd1; op_rs1 = 5'd2; op_rd = 5'd15;
      @(negedge clk); // T1
      op_valid = 1'b0;
      @(negedge clk); // T2
      checks++;
      if (rf_rd !== 1'b1) begin
         errors++; $display("FAIL rstmid_t2_rd got %b want 1", rf_rd);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rf_rd, rf_wt, eop, err, busy, op_ready} !== 6'b000001) begin
         errors++; $display("FAIL rstmid_async got %b want 000001", {rf_rd, rf_wt, eop, err, busy, op_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
      saw_wt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rf_wt !== 1'b0) saw_wt = 1'b1;
      end
      checks++;
      if ({saw_wt, op_ready} !== 2'b01) begin
         errors++; $display("FAIL rstmid_after saw_wt/ready got %b want 01", {saw_wt, op_ready});
      end
      run_op("add_after_rst", 4'd0, 5'd1, 5'd2, 5'd15, 1'b1, 32'd12, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_sll();
      test_logic();
      test_mul();
      test_illegal();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kore_exec_fsm.md
# kore_exec_fsm

Parametrised execute sequencer for the kore datapath. Accepts one decoded register-register operation over a valid/ready handshake, reads both source operands from the register file through a single read port, computes the result in an ALU, writes it back to the destination register, and pulses end-of-operation. It sits between the instruction decoder and the register file, replacing the fixed 32-bit three-op functional FSM.

## Interface

- DW, 32, datapath width; power of two, 8..64
- AW, 5, register-file address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  decoder presents an operation
- op_ready  out  1  block can accept an operation; high only in IDLE
- op_code  in  4  operation select
- op_rs0, op_rs1, op_rd  in  AW each  source 0, source 1 and destination register addresses
- rf_rd  out  1  register-file read strobe
- rf_raddr  out  AW  read address
- rf_rdata  in  DW  read data, valid the cycle after rf_rd
- rf_wt  out  1  register-file write enable
- rf_waddr  out  AW  write address
- rf_wdata  out  DW  write data
- busy  out  1  high in every state except IDLE
- eop  out  1  one-cycle end-of-operation pulse
- err  out  1  one-cycle pulse coincident with eop on an illegal op_code

## Operation

- FSM states: IDLE, RD0, RD1, EXEC, WB. Transitions: IDLE->RD0 on op_valid&&op_ready; RD0->RD1->EXEC->WB unconditionally; WB->IDLE.
- Accept: op_code, op_rs0, op_rs1 and op_rd are captured on the handshake. Input changes while busy are ignored.
- RD0: rf_rd=1, rf_raddr=rs0.
- RD1: rf_rd=1, rf_raddr=rs1. rf_rdata (rs0) is captured into operand A.
- EXEC: rf_rd=0. The ALU combines A with rf_rdata (rs1, operand B). The result and an illegal flag are registered.
- WB: eop=1. For a legal op: rf_wt=1, rf_waddr=rd, rf_wdata=result. For an illegal op: rf_wt=0, err=1.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SLL (A<<B), 7 SRL (A>>B, logical), 8 PASS (A). Codes 9..15 are illegal.
- Arithmetic: ADD, SUB and MUL are unsigned modulo 2^DW, keeping the low DW bits, with no flags. The shift amount is B[$clog2(DW)-1:0].
- rs0==rs1 is legal; the register is read twice. rd may equal rs0 or rs1, because the write occurs after both reads.
- Reset values: all outputs 0 except op_ready=1 (state IDLE). Operand and result registers reset to 0.
- Reset mid-operation: the state returns to IDLE immediately, and rf_rd, rf_wt, eop and err drop asynchronously. The aborted op produces no write.

## Timing

- T0 is the accept cycle. rf_rd is high in T1 and T2. rf_wt, eop and err are valid in T4. op_ready returns in T5.
- Latency from accept to write-back is 4 cycles. Maximum throughput is one op per 5 cycles.
- All outputs are registered or decoded directly from state. There is no combinational path from op_* to any output except through op_ready.

## Configuration

- KORE_EXEC_MUL_EN defined: opcode 2 instantiates a DW×DW multiplier and writes the low DW bits.
- KORE_EXEC_MUL_EN undefined: no multiplier is synthesised, and opcode 2 is treated as illegal (err=1, no write). Timing is otherwise identical.

## Structure

- Package kore_exec_pkg holds the op_code localparams (OP_ADD … OP_PASS), the state enum type, and a function that checks op_code legality.
- Sub-module kore_exec_alu is purely combinational, with inputs A, B and op_code and outputs result and illegal. The multiplier ifdef lives here.
- kore_exec_fsm holds the FSM, the operand/result registers and the register-file port logic.

## Test plan

- Preload RF r1=5, r2=7, then ADD rs0=1 rs1=2 rd=3 (DW=32) -> T1/T2 rf_raddr=1 then 2; T4 rf_wt=1, rf_waddr=3, rf_wdata=12, eop=1; op_ready=1 at T5.
- SUB with r1=3, r2=5 -> rf_wdata=0xFFFFFFFE. SLL with r1=1, r2=0x21 -> 0x00000002 (shift amount 1).
- MUL with r1=r2=0x00010000 and the macro defined -> rf_wdata=0. MUL with the macro undefined -> T4 eop=1, err=1, rf_wt=0.
- op_code=0xF -> eop=1, err=1, rf_wt=0, block back in IDLE at T5.
- op_valid held high with 3 queued ops, fields changed mid-operation -> accepts only in IDLE at 5-cycle spacing; each write uses the fields captured at its accept.
- rst_n asserted during T2 of an ADD -> rf_rd=0 immediately, no rf_wt, op_ready=1 after release; a following ADD completes normally.
